// File: rtl/video_pkg.sv
// Package: video_pkg
// Shared definitions for the video subsystem (fetcher, CRTC, line buffers).
//   fetch_state_t    : fetcher FSM encoding (IDLE=0, FETCH=1)
//   VF_ADR_W         : default Wishbone halfword address width
//   VF_LB_W          : default line-buffer address width
//   LEN_ZERO_IS_MAX  : a line length of 0 encodes 2**LB_W halfwords
package video_pkg;

  localparam int VF_ADR_W = 23;
  localparam int VF_LB_W  = 9;
  localparam bit LEN_ZERO_IS_MAX = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/video_fetch_ctr.sv
// Module: video_fetch_ctr
// Line-buffer index counter with terminal-count compare for one scanline burst.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : latch i_len and restart the index at 0
//   i_len          : halfwords per line (0 encodes 2**LB_W)
//   i_adv          : one halfword accepted, advance the index
//   o_idx          : line-buffer address of the current halfword
//   o_last         : current halfword is the final one of the line
module video_fetch_ctr
  import video_pkg::*;
#(
  parameter int LB_W = VF_LB_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [LB_W-1:0] i_len,
  input  logic            i_adv,
  output logic [LB_W-1:0] o_idx,
  output logic            o_last
);

  logic [LB_W-1:0] r_len;
  logic [LB_W-1:0] r_idx;
  logic [LB_W-1:0] w_len_m1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_len <= i_len;
      r_idx <= '0;
    end else if (i_adv) begin
      r_idx <= r_idx + LB_W'(1);
    end
  end

  // len-1 wraps to all ones for len==0, so a zero length runs the full
  // 2**LB_W halfwords and the index wraps back to 0 on the final beat.
  assign w_len_m1 = r_len - LB_W'(1);
  assign o_idx    = r_idx;
  assign o_last   = (LEN_ZERO_IS_MAX || (r_len != '0)) ? (r_idx == w_len_m1) : 1'b1;

endmodule

// File: rtl/video_fetcher.sv
// Module: video_fetcher
// Wishbone B3 classic read master that fills the off-screen scanline buffer.
// Each START_I fetches one line of LEN_I halfwords from video memory, starting
// at the running fetch pointer, and writes them through the S_* store port.
// VSYNC_I reloads the pointer from PTR_I (aborting any burst) and clears
// OVERRUN_O.
// Ports:
//   CLK_I, RST_N_I        : clock, asynchronous active-low reset
//   VSYNC_I, PTR_I        : frame-start pulse and frame base address
//   START_I, LEN_I        : line-start pulse and line length (0 = 2**LB_W)
//   MOD_I                 : line modulo (only with VIDEO_FETCHER_MODULO_EN)
//   ADR_O/CYC_O/STB_O/WE_O, ACK_I, DAT_I : Wishbone master port
//   S_ADR_O/S_DAT_O/S_WE_O : line-buffer store port
//   BUSY_O, OVERRUN_O     : burst active, sticky START-while-busy flag
// Configuration macro: VIDEO_FETCHER_MODULO_EN adds MOD_I; a completed line
// then advances the pointer by 1+MOD_I instead of 1.
module video_fetcher
  import video_pkg::*;
#(
  parameter int ADR_W = VF_ADR_W,
  parameter int LB_W  = VF_LB_W
) (
  input  logic             CLK_I,
  input  logic             RST_N_I,
  input  logic             VSYNC_I,
  input  logic             START_I,
  input  logic [ADR_W-1:0] PTR_I,
  input  logic [LB_W-1:0]  LEN_I,
`ifdef VIDEO_FETCHER_MODULO_EN
  input  logic [ADR_W-1:0] MOD_I,
`endif
  output logic [ADR_W-1:0] ADR_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I,
  input  logic [15:0]      DAT_I,
  output logic [LB_W-1:0]  S_ADR_O,
  output logic [15:0]      S_DAT_O,
  output logic             S_WE_O,
  output logic             BUSY_O,
  output logic             OVERRUN_O
);

  fetch_state_t     r_state;
  logic             r_pend;
  logic             r_cyc;
  logic             r_ovr;
  logic             r_swe;
  logic [ADR_W-1:0] r_ptr;
  logic [LB_W-1:0]  r_sadr;
  logic [15:0]      r_sdat;

  logic             w_load;
  logic             w_adv;
  logic             w_last;
  logic             w_busy;
  logic [LB_W-1:0]  w_idx;
  logic [ADR_W-1:0] w_mod;

`ifdef VIDEO_FETCHER_MODULO_EN
  assign w_mod = MOD_I;
`else
  assign w_mod = '0;
`endif

  // A START accepted in IDLE arms r_pend; the bus cycle opens one edge later.
  // The armed cycle already counts as busy for overrun detection.
  assign w_busy = (r_state == FETCH) || r_pend;
  assign w_load = (r_state == IDLE) && !r_pend && START_I;
  // An ACK coinciding with VSYNC is discarded by the abort.
  assign w_adv  = (r_state == FETCH) && ACK_I && !VSYNC_I;

  video_fetch_ctr #(
    .LB_W (LB_W)
  ) u_ctr (
    .i_clk   (CLK_I),
    .i_rst_n (RST_N_I),
    .i_load  (w_load),
    .i_len   (LEN_I),
    .i_adv   (w_adv),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_cyc   <= 1'b0;
      r_ovr   <= 1'b0;
      r_swe   <= 1'b0;
      r_ptr   <= '0;
      r_sadr  <= '0;
      r_sdat  <= '0;
    end else begin
      r_swe <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // Reload first so a same-edge START launches at the new base.
          if (VSYNC_I) r_ptr <= PTR_I;
          if (r_pend) begin
            r_pend  <= 1'b0;
            r_cyc   <= 1'b1;
            r_state <= FETCH;
          end else if (START_I) begin
            r_pend <= 1'b1;
          end
        end
        FETCH: begin
          if (VSYNC_I) begin
            r_cyc   <= 1'b0;
            r_state <= IDLE;
            r_ptr   <= PTR_I;
          end else if (ACK_I) begin
            r_swe  <= 1'b1;
            r_sadr <= w_idx;
            r_sdat <= DAT_I;
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_state <= IDLE;
              r_ptr   <= r_ptr + ADR_W'(1) + w_mod;
            end else begin
              r_ptr <= r_ptr + ADR_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (VSYNC_I) r_ovr <= 1'b0;
      if (START_I && w_busy) r_ovr <= 1'b1;
    end
  end

  assign ADR_O     = r_ptr;
  assign CYC_O     = r_cyc;
  assign STB_O     = r_cyc;
  assign WE_O      = 1'b0;
  assign BUSY_O    = r_cyc;
  assign S_ADR_O   = r_sadr;
  assign S_DAT_O   = r_sdat;
  assign S_WE_O    = r_swe;
  assign OVERRUN_O = r_ovr;

endmodule

// File: tb/tb_video_fetcher.sv
// Testbench for video_fetcher: Wishbone slave with programmable wait states,
// a line-level reference model compared every cycle, and directed scenarios
// with hand-computed expectations.
module tb_video_fetcher;

  localparam int AW   = 23;
  localparam int LW   = 9;
  localparam int AMOD = 1 << AW;
`ifdef VIDEO_FETCHER_MODULO_EN
  localparam int M_MOD = 16;
`else
  localparam int M_MOD = 0;
`endif

  logic          clk = 1'b0;
  logic          RST_N_I = 1'b0;
  logic          vs_main = 1'b0;
  logic          vs_ack = 1'b0;
  logic          VSYNC_I;
  logic          START_I = 1'b0;
  logic [AW-1:0] PTR_I = '0;
  logic [LW-1:0] LEN_I = '0;
  logic [AW-1:0] MOD_I = AW'(M_MOD);
  logic [AW-1:0] ADR_O;
  logic          CYC_O, STB_O, WE_O;
  logic          ACK_I = 1'b0;
  logic [15:0]   DAT_I = '0;
  logic [LW-1:0] S_ADR_O;
  logic [15:0]   S_DAT_O;
  logic          S_WE_O, BUSY_O, OVERRUN_O;

  assign VSYNC_I = vs_main | vs_ack;

  always #5 clk = ~clk;

  video_fetcher #(.ADR_W(AW), .LB_W(LW)) dut (
    .CLK_I     (clk),
    .RST_N_I   (RST_N_I),
    .VSYNC_I   (VSYNC_I),
    .START_I   (START_I),
    .PTR_I     (PTR_I),
    .LEN_I     (LEN_I),
`ifdef VIDEO_FETCHER_MODULO_EN
    .MOD_I     (MOD_I),
`endif
    .ADR_O     (ADR_O),
    .CYC_O     (CYC_O),
    .STB_O     (STB_O),
    .WE_O      (WE_O),
    .ACK_I     (ACK_I),
    .DAT_I     (DAT_I),
    .S_ADR_O   (S_ADR_O),
    .S_DAT_O   (S_DAT_O),
    .S_WE_O    (S_WE_O),
    .BUSY_O    (BUSY_O),
    .OVERRUN_O (OVERRUN_O)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wishbone slave: ack_dly wait states per beat; data = address + dat_off.
  // When vs_on_ack is nonzero, VSYNC is raised together with that ACK number.
  int          ack_dly = 0;
  int          vs_on_ack = 0;
  logic [15:0] dat_off = '0;
  int          wcnt = 0;
  int          ack_n = 0;

  always @(negedge clk) begin
    vs_ack = 1'b0;
    if (CYC_O && STB_O) begin
      if (wcnt >= ack_dly) begin
        ACK_I = 1'b1;
        wcnt  = 0;
        ack_n++;
        if (vs_on_ack != 0 && ack_n == vs_on_ack) vs_ack = 1'b1;
      end else begin
        ACK_I = 1'b0;
        wcnt++;
      end
    end else begin
      ACK_I = 1'b0;
      wcnt  = 0;
      ack_n = 0;
    end
    DAT_I = ADR_O[15:0] + dat_off;
  end

  // Reference model: line-level bookkeeping (beats left, integer pointer).
  int          m_ptr = 0;
  int          m_left = 0;
  int          m_idx = 0;
  bit          m_busy = 0, m_pend = 0, m_ovr = 0, m_we = 0;
  logic [8:0]  m_sadr = '0;
  logic [15:0] m_sdat = '0;

  logic [15:0]   lb [512];
  int            store_cnt = 0;
  logic [AW-1:0] adr_q [$];

  logic          s_rst, s_ack, s_vs, s_st;
  logic [AW-1:0] s_pin;
  logic [LW-1:0] s_len;
  logic [15:0]   s_dat;
  bit            was_busy;

  always @(posedge clk) begin
    s_rst = RST_N_I; s_ack = ACK_I; s_vs = VSYNC_I; s_st = START_I;
    s_pin = PTR_I; s_len = LEN_I; s_dat = DAT_I;
    if (RST_N_I && CYC_O && STB_O && ACK_I && !VSYNC_I) adr_q.push_back(ADR_O);
    was_busy = m_busy || m_pend;
    if (!s_rst) begin
      m_ptr = 0; m_left = 0; m_idx = 0;
      m_busy = 0; m_pend = 0; m_ovr = 0; m_we = 0;
      m_sadr = '0; m_sdat = '0;
    end else begin
      m_we = 0;
      if (m_busy) begin
        if (s_vs) begin
          m_busy = 0;
          m_ptr  = int'(s_pin);
        end else if (s_ack) begin
          m_we   = 1;
          m_sadr = m_idx[8:0];
          m_sdat = s_dat;
          m_idx++;
          m_left--;
          m_ptr = (m_ptr + 1) % AMOD;
          if (m_left == 0) begin
            m_busy = 0;
            m_ptr  = (m_ptr + M_MOD) % AMOD;
          end
        end
      end else begin
        if (s_vs) m_ptr = int'(s_pin);
        if (m_pend) begin
          m_pend = 0;
          m_busy = 1;
        end else if (s_st) begin
          m_pend = 1;
          m_idx  = 0;
          m_left = (s_len == 0) ? 512 : int'(s_len);
        end
      end
      if (s_vs) m_ovr = 0;
      if (s_st && was_busy) m_ovr = 1;
    end
    #1;
    chk("cyc", 32'(CYC_O), 32'(m_busy));
    chk("stb", 32'(STB_O), 32'(m_busy));
    chk("busy", 32'(BUSY_O), 32'(m_busy));
    chk("we", 32'(WE_O), 32'h0);
    chk("adr", 32'(ADR_O), 32'(m_ptr));
    chk("s_we", 32'(S_WE_O), 32'(m_we));
    chk("s_adr", 32'(S_ADR_O), 32'(m_sadr));
    chk("s_dat", 32'(S_DAT_O), 32'(m_sdat));
    chk("overrun", 32'(OVERRUN_O), 32'(m_ovr));
    if (S_WE_O) begin
      lb[S_ADR_O] = S_DAT_O;
      store_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_vsync(input logic [AW-1:0] p);
    vs_main = 1'b1;
    PTR_I   = p;
    @(negedge clk);
    vs_main = 1'b0;
  endtask

  task automatic do_start(input logic [LW-1:0] len);
    START_I = 1'b1;
    LEN_I   = len;
    @(negedge clk);
    START_I = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((m_busy || m_pend) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (m_busy || m_pend) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: burst still active after %0d cycles", budget);
    end
    tick(2);
  endtask

  int base_st;
  int base_q;
  int bad;

  initial begin
    // Reset state
    tick(3);
    chk("rst_cyc", 32'(CYC_O), 32'h0);
    chk("rst_busy", 32'(BUSY_O), 32'h0);
    chk("rst_swe", 32'(S_WE_O), 32'h0);
    chk("rst_ovr", 32'(OVERRUN_O), 32'h0);
    chk("rst_adr", 32'(ADR_O), 32'h0);
    RST_N_I = 1'b1;
    tick(2);

    // 1: zero-wait line of 4
    base_st = store_cnt; base_q = adr_q.size();
    do_vsync(23'h1000);
    do_start(9'd4);
    wait_done(100);
    chk("t1_stores", 32'(store_cnt - base_st), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_adr", 32'(adr_q[base_q + i]), 32'h1000 + 32'(i));
      chk("t1_lb", 32'(lb[i]), 32'h1000 + 32'(i));
    end
    chk("t1_busy", 32'(BUSY_O), 32'h0);

    // 2: three wait states per beat, data 0xA5A5+n
    ack_dly = 3; dat_off = 16'h85A5;
    base_st = store_cnt;
    do_vsync(23'h2000);
    do_start(9'd4);
    wait_done(200);
    chk("t2_stores", 32'(store_cnt - base_st), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_lb", 32'(lb[i]), 32'hA5A5 + 32'(i));

    // 3: START during a burst
    ack_dly = 1; dat_off = '0;
    base_st = store_cnt;
    do_start(9'd4);
    tick(3);
    do_start(9'd4);
    wait_done(200);
    chk("t3_ovr", 32'(OVERRUN_O), 32'h1);
    chk("t3_stores", 32'(store_cnt - base_st), 32'd4);
    do_vsync(23'h3000);
    tick(1);
    chk("t3_ovr_clr", 32'(OVERRUN_O), 32'h0);

    // 4: length 0 = 512 beats, pointer wrap
    ack_dly = 0;
    base_st = store_cnt; base_q = adr_q.size();
    do_vsync(23'h7FFFFE);
    do_start(9'd0);
    wait_done(2000);
    chk("t4_stores", 32'(store_cnt - base_st), 32'd512);
    chk("t4_adr0", 32'(adr_q[base_q]), 32'h7FFFFE);
    chk("t4_adr1", 32'(adr_q[base_q + 1]), 32'h7FFFFF);
    chk("t4_adr2", 32'(adr_q[base_q + 2]), 32'h000000);
    chk("t4_adr511", 32'(adr_q[base_q + 511]), 32'h0001FD);
    bad = 0;
    for (int i = 0; i < 512; i++) if (lb[i] !== 16'(16'hFFFE + i)) bad++;
    chk("t4_lb_bad", 32'(bad), 32'd0);

    // 5a: VSYNC on the 3rd ACK of an 8-beat line
    base_st = store_cnt;
    do_vsync(23'h4000);
    vs_on_ack = 3;
    do_start(9'd8);
    wait_done(100);
    vs_on_ack = 0;
    chk("t5_stores", 32'(store_cnt - base_st), 32'd2);
    chk("t5_cyc", 32'(CYC_O), 32'h0);
    base_q = adr_q.size();
    do_start(9'd2);
    wait_done(100);
    chk("t5_restart", 32'(adr_q[base_q]), 32'h4000);

    // 5b: reset mid-burst drops the bus at once
    ack_dly = 2;
    do_start(9'd8);
    tick(4);
    chk("t5_cyc_up", 32'(CYC_O), 32'h1);
    #2 RST_N_I = 1'b0;
    #1;
    chk("t5_rst_cyc", 32'(CYC_O), 32'h0);
    chk("t5_rst_busy", 32'(BUSY_O), 32'h0);
    @(negedge clk);
    RST_N_I = 1'b1;
    tick(2);

    // 6: line-to-line pointer advance (with/without modulo)
    ack_dly = 0;
    do_vsync(23'h100);
    do_start(9'd4);
    wait_done(100);
    base_q = adr_q.size();
    do_start(9'd4);
    wait_done(100);
    chk("t6_line2", 32'(adr_q[base_q]), (M_MOD != 0) ? 32'h114 : 32'h104);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
